// File: rtl/spi1_pkg.sv
// Shared definitions for the SPI1 command decoder.
// Holds the command opcode encodings (taken from rx byte bits [7:5]),
// the decoder FSM state type and the default bus address width.
package spi1_pkg;

    localparam int ADDR_WIDTH = 17;

    localparam logic [2:0] OP_WRITE_AT   = 3'b100;
    localparam logic [2:0] OP_READ_AT    = 3'b110;
    localparam logic [2:0] OP_WRITE_NEXT = 3'b010;
    localparam logic [2:0] OP_READ_NEXT  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_REQ     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/spi1_cmd_decoder.sv
// SPI1 command decoder.
// Turns the bytes of one SPI frame into a single bus read or write,
// holds the request until the arbiter acknowledges it, and returns read
// data as the next TX byte. *_NEXT commands use an internal address that
// auto-increments from the last issued request.
//
// Ports
//   sys_clock_i, sys_reset_n_i     clock, async active-low reset
//   spi_cs_active_i                frame active (synchronous to sys_clock_i)
//   rx_data_i / rx_valid_i         received byte + one-cycle strobe
//   tx_data_o / tx_valid_o         read data for the next SPI transfer + strobe
//   bus_req_o/we/addr/wr_data      request to arbiter, held until bus_ack_i
//   bus_ack_i / bus_rd_data_i      request serviced + read data
//   busy_o                         mirrors bus_req_o
//   overrun_o                      sticky: byte arrived while a request was pending
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for the opcode byte of a frame
// ST_ADDR_HI | *_AT: waiting for address bits 15..8
// ST_ADDR_LO | *_AT: waiting for address bits 7..0
// ST_DATA    | write: waiting for the data byte
// ST_REQ     | bus request held until bus_ack_i
// ST_DONE    | frame finished or bad opcode; ignore bytes until CS falls
module spi1_cmd_decoder
    import spi1_pkg::*;
#(
    parameter int ADDR_WIDTH = spi1_pkg::ADDR_WIDTH
) (
    input  logic                  sys_clock_i,
    input  logic                  sys_reset_n_i,
    input  logic                  spi_cs_active_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [7:0]            bus_wr_data_o,
    input  logic                  bus_ack_i,
    input  logic [7:0]            bus_rd_data_i,
    output logic                  busy_o,
    output logic                  overrun_o
);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_is_at;
    logic                    r_is_we;
    logic                    r_a16;
    logic [7:0]              r_a_hi;
    logic [7:0]              r_a_lo;
    logic                    r_cs_d;

    logic                    r_bus_req;
    logic                    r_bus_we;
    logic [ADDR_WIDTH-1:0]   r_bus_addr;
    logic [7:0]              r_bus_wr_data;
    logic [7:0]              r_tx_data;
    logic                    r_tx_valid;
    logic                    r_overrun;

    logic                    w_rx_ok;
    logic                    w_issue;
    logic                    w_issue_we;
    logic                    w_overrun_set;
    logic                    w_cs_rise;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [ADDR_WIDTH-1:0]   w_issue_addr;

    // A byte arriving together with CS falling is discarded.
    assign w_rx_ok     = rx_valid_i & spi_cs_active_i;
    assign w_cs_rise   = spi_cs_active_i & ~r_cs_d;
    assign w_next_addr = r_addr + ADDR_WIDTH'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_issue_we    = 1'b0;
        w_overrun_set = 1'b0;
        w_issue_addr  = w_next_addr;

        case (r_state)
            ST_IDLE: begin
                if (w_rx_ok) begin
                    case (rx_data_i[7:5])
                        OP_WRITE_AT,
                        OP_READ_AT:    w_state_nxt = ST_ADDR_HI;
                        OP_WRITE_NEXT: w_state_nxt = ST_DATA;
                        OP_READ_NEXT: begin
                            w_state_nxt = ST_REQ;
                            w_issue     = 1'b1;
                        end
                        default:       w_state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (!spi_cs_active_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rx_ok) begin
                    w_state_nxt = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                // READ_AT completes here, using the low address byte straight off rx.
                w_issue_addr = ADDR_WIDTH'({r_a16, r_a_hi, rx_data_i});
                if (!spi_cs_active_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rx_ok) begin
                    if (r_is_we) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_REQ;
                        w_issue     = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (r_is_at) begin
                    w_issue_addr = ADDR_WIDTH'({r_a16, r_a_hi, r_a_lo});
                end
                w_issue_we = 1'b1;
                if (!spi_cs_active_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rx_ok) begin
                    w_state_nxt = ST_REQ;
                    w_issue     = 1'b1;
                end
            end
            ST_REQ: begin
                // CS is ignored here so an accepted bus cycle always completes.
                if (bus_ack_i) begin
                    w_state_nxt = spi_cs_active_i ? ST_DONE : ST_IDLE;
                end else if (rx_valid_i) begin
                    w_overrun_set = 1'b1;
                end
            end
            ST_DONE: begin
                if (!spi_cs_active_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            r_addr        <= '0;
            r_is_at       <= 1'b0;
            r_is_we       <= 1'b0;
            r_a16         <= 1'b0;
            r_a_hi        <= '0;
            r_a_lo        <= '0;
            r_cs_d        <= 1'b0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_cs_d     <= spi_cs_active_i;
            r_tx_valid <= 1'b0;

            if (r_state == ST_IDLE && w_rx_ok) begin
                r_is_at <= rx_data_i[7];
                r_is_we <= ~rx_data_i[6];
                r_a16   <= rx_data_i[0];
            end
            if (r_state == ST_ADDR_HI && w_rx_ok) begin
                r_a_hi <= rx_data_i;
            end
            if (r_state == ST_ADDR_LO && w_rx_ok) begin
                r_a_lo <= rx_data_i;
            end

            if (w_issue) begin
                r_bus_req     <= 1'b1;
                r_bus_we      <= w_issue_we;
                r_bus_addr    <= w_issue_addr;
                r_bus_wr_data <= rx_data_i;
                r_addr        <= w_issue_addr;
            end else if (r_state == ST_REQ && bus_ack_i) begin
                r_bus_req <= 1'b0;
                if (!r_bus_we) begin
                    r_tx_data  <= bus_rd_data_i;
                    r_tx_valid <= 1'b1;
                end
            end

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_cs_rise) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign tx_data_o     = r_tx_data;
    assign tx_valid_o    = r_tx_valid;
    assign bus_req_o     = r_bus_req;
    assign bus_we_o      = r_bus_we;
    assign bus_addr_o    = r_bus_addr;
    assign bus_wr_data_o = r_bus_wr_data;
    assign busy_o        = r_bus_req;
    assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_spi1_cmd_decoder.sv
module tb_spi1_cmd_decoder;
    import spi1_pkg::*;

    localparam int AW = 17;

    localparam int S_REQ   = 0;
    localparam int S_WE    = 1;
    localparam int S_ADDR  = 2;
    localparam int S_WDATA = 3;
    localparam int S_TXV   = 4;
    localparam int S_TXD   = 5;
    localparam int S_BUSY  = 6;
    localparam int S_OVR   = 7;
    localparam int S_LIT   = 8;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        logic [31:0] lit;
        string       name;
    } chk_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } req_t;

    logic          clk;
    logic          rst_n;
    logic          cs;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wr_data;
    logic          bus_ack;
    logic [7:0]    bus_rd_data;
    logic          busy;
    logic          overrun;

    chk_t       chk_q[$];
    req_t       req_q[$];
    logic [7:0] tx_q[$];

    int n_vec = 0;
    int n_err = 0;

    spi1_cmd_decoder #(.ADDR_WIDTH(AW)) dut (
        .sys_clock_i     (clk),
        .sys_reset_n_i   (rst_n),
        .spi_cs_active_i (cs),
        .rx_data_i       (rx_data),
        .rx_valid_i      (rx_valid),
        .tx_data_o       (tx_data),
        .tx_valid_o      (tx_valid),
        .bus_req_o       (bus_req),
        .bus_we_o        (bus_we),
        .bus_addr_o      (bus_addr),
        .bus_wr_data_o   (bus_wr_data),
        .bus_ack_i       (bus_ack),
        .bus_rd_data_i   (bus_rd_data),
        .busy_o          (busy),
        .overrun_o       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor / scoreboard ----------------
    chk_t       m_c;
    req_t       m_e;
    req_t       m_held;
    logic [31:0] m_act;
    logic [7:0] m_tx;
    logic       prev_req = 1'b0;
    logic       prev_txv = 1'b0;

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            m_c = chk_q.pop_front();
            case (m_c.sel)
                S_REQ:   m_act = 32'(bus_req);
                S_WE:    m_act = 32'(bus_we);
                S_ADDR:  m_act = 32'(bus_addr);
                S_WDATA: m_act = 32'(bus_wr_data);
                S_TXV:   m_act = 32'(tx_valid);
                S_TXD:   m_act = 32'(tx_data);
                S_BUSY:  m_act = 32'(busy);
                S_OVR:   m_act = 32'(overrun);
                default: m_act = m_c.lit;
            endcase
            n_vec++;
            if (m_act !== m_c.exp) begin
                n_err++;
                $display("FAIL %s: got %0h, expected %0h", m_c.name, m_act, m_c.exp);
            end
        end

        if (bus_req && !prev_req) begin
            n_vec++;
            if (req_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_req: got we=%0b addr=%05h, expected no request", bus_we, bus_addr);
            end else begin
                m_e = req_q.pop_front();
                if (bus_we !== m_e.we || bus_addr !== m_e.addr ||
                    (m_e.we && bus_wr_data !== m_e.data)) begin
                    n_err++;
                    $display("FAIL req: got we=%0b addr=%05h data=%02h, expected we=%0b addr=%05h data=%02h",
                             bus_we, bus_addr, bus_wr_data, m_e.we, m_e.addr, m_e.data);
                end
            end
            m_held.we   = bus_we;
            m_held.addr = bus_addr;
            m_held.data = bus_wr_data;
        end else if (bus_req && prev_req) begin
            n_vec++;
            if (bus_we !== m_held.we || bus_addr !== m_held.addr || bus_wr_data !== m_held.data) begin
                n_err++;
                $display("FAIL req_stable: got we=%0b addr=%05h data=%02h, expected we=%0b addr=%05h data=%02h",
                         bus_we, bus_addr, bus_wr_data, m_held.we, m_held.addr, m_held.data);
            end
        end

        if (tx_valid) begin
            n_vec++;
            if (prev_txv) begin
                n_err++;
                $display("FAIL tx_valid_width: got 2+ cycles, expected 1");
            end
            n_vec++;
            if (tx_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_tx: got %02h, expected no tx", tx_data);
            end else begin
                m_tx = tx_q.pop_front();
                if (tx_data !== m_tx) begin
                    n_err++;
                    $display("FAIL tx_data: got %02h, expected %02h", tx_data, m_tx);
                end
            end
        end

        prev_req = bus_req;
        prev_txv = tx_valid;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void chk(int sel, logic [31:0] exp, string name, logic [31:0] lit = 0);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.lit  = lit;
        c.name = name;
        chk_q.push_back(c);
    endfunction

    function automatic void exp_req(logic we, logic [AW-1:0] addr, logic [7:0] data);
        req_t r;
        r.we   = we;
        r.addr = addr;
        r.data = data;
        req_q.push_back(r);
    endfunction

    task automatic send_byte(logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    // Last command byte: request must be visible the cycle after the strobe.
    task automatic send_last(logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk(S_REQ, 1, "req_latency");
        tick();
    endtask

    task automatic cs_on();
        cs = 1'b1;
        tick();
    endtask

    task automatic cs_off();
        cs = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus_req && n < 20) begin
            tick();
            n++;
        end
        chk(S_REQ, 1, "req_wait");
    endtask

    task automatic do_ack(logic [7:0] rd, int delay);
        wait_req();
        repeat (delay) tick();
        bus_ack     = 1'b1;
        bus_rd_data = rd;
        tick();
        bus_ack     = 1'b0;
        bus_rd_data = 8'h00;
        chk(S_REQ, 0, "req_drop");
        tick();
    endtask

    task automatic chk_all_zero(string tag);
        chk(S_REQ,   0, {tag, "_req"});
        chk(S_BUSY,  0, {tag, "_busy"});
        chk(S_WE,    0, {tag, "_we"});
        chk(S_ADDR,  0, {tag, "_addr"});
        chk(S_WDATA, 0, {tag, "_wdata"});
        chk(S_TXV,   0, {tag, "_txv"});
        chk(S_TXD,   0, {tag, "_txd"});
        chk(S_OVR,   0, {tag, "_ovr"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        cs          = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        bus_ack     = 1'b0;
        bus_rd_data = 8'h00;
        tick();
        chk_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: WRITE_AT 0x01234 <- A5
        cs_on();
        exp_req(1'b1, 17'h01234, 8'hA5);
        send_byte(8'h80);
        send_byte(8'h12);
        send_byte(8'h34);
        send_last(8'hA5);
        do_ack(8'h00, 1);
        cs_off();

        // 2: READ_AT 0x1FFFF -> 3C
        cs_on();
        exp_req(1'b0, 17'h1FFFF, 8'h00);
        tx_q.push_back(8'h3C);
        send_byte(8'hC1);
        send_byte(8'hFF);
        send_last(8'hFF);
        do_ack(8'h3C, 2);
        cs_off();

        // 3: READ_NEXT wraps to 0, WRITE_NEXT -> 1
        cs_on();
        exp_req(1'b0, 17'h00000, 8'h00);
        tx_q.push_back(8'h5A);
        send_last(8'h20);
        do_ack(8'h5A, 0);
        cs_off();
        cs_on();
        exp_req(1'b1, 17'h00001, 8'h77);
        send_byte(8'h40);
        send_last(8'h77);
        do_ack(8'h00, 0);
        cs_off();

        // 4: aborted frame, bad opcode, then READ_AT 0x00010
        cs_on();
        send_byte(8'h80);
        send_byte(8'h12);
        cs_off();
        chk(S_REQ, 0, "abort_no_req");
        cs_on();
        send_byte(8'hFF);
        send_byte(8'h00);
        chk(S_REQ, 0, "badop_no_req");
        cs_off();
        cs_on();
        exp_req(1'b0, 17'h00010, 8'h00);
        tx_q.push_back(8'h99);
        send_byte(8'hC0);
        send_byte(8'h00);
        send_last(8'h10);
        do_ack(8'h99, 0);
        cs_off();

        // 5: overrun while ack withheld; cleared by next CS rise
        cs_on();
        exp_req(1'b1, 17'h00020, 8'h11);
        send_byte(8'h80);
        send_byte(8'h00);
        send_byte(8'h20);
        send_last(8'h11);
        send_byte(8'hEE);
        chk(S_OVR, 1, "overrun_set");
        do_ack(8'h00, 3);
        cs_off();
        chk(S_OVR, 1, "overrun_sticky");
        cs_on();
        chk(S_OVR, 0, "overrun_clear");
        // byte strobed together with ack is not an overrun
        exp_req(1'b0, 17'h00021, 8'h00);
        tx_q.push_back(8'h6B);
        send_last(8'h20);
        bus_ack     = 1'b1;
        bus_rd_data = 8'h6B;
        rx_data     = 8'h55;
        rx_valid    = 1'b1;
        tick();
        bus_ack  = 1'b0;
        rx_valid = 1'b0;
        chk(S_OVR, 0, "ack_rx_no_overrun");
        chk(S_REQ, 0, "ack_rx_req_drop");
        tick();
        cs_off();

        // 6: reset during request, then READ_NEXT from cleared address
        cs_on();
        exp_req(1'b0, 17'h00040, 8'h00);
        send_byte(8'hC0);
        send_byte(8'h00);
        send_last(8'h40);
        rst_n = 1'b0;
        chk_all_zero("midreq_reset");
        tick();
        tick();
        rst_n = 1'b1;
        cs_off();
        cs_on();
        exp_req(1'b0, 17'h00001, 8'h00);
        tx_q.push_back(8'h42);
        send_last(8'h20);
        do_ack(8'h42, 1);
        cs_off();

        repeat (3) tick();
        chk(S_LIT, 0, "req_q_drained", 32'(req_q.size()));
        chk(S_LIT, 0, "tx_q_drained", 32'(tx_q.size()));
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
